// File: rtl/io_intr_pkg.sv
// rtl/io_intr_pkg.sv - register offsets, CTRL bit positions and FSM encoding for io_intr_ctrl
package io_intr_pkg;
    localparam int PEND_OFS = 'h0;
    localparam int MASK_OFS = 'h4;
    localparam int CTRL_OFS = 'h8;
    localparam int EOI_OFS  = 'hC;

    localparam int CTRL_GIE_BIT   = 0;
    localparam int CTRL_INSVC_BIT = 1;
    localparam int CTRL_IVEC_LSB  = 4;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        REQ  = 2'd1,
        SVC  = 2'd2
    } intr_state_t;
endpackage

// File: rtl/io_intr_prio.sv
// rtl/io_intr_prio.sv - lowest-index-wins priority encoder over NDEV request bits
module io_intr_prio
    import io_intr_pkg::*;
#(
    parameter int NDEV = 4
) (
    input  logic [NDEV-1:0] req,
    output logic            valid,
    output logic [2:0]      id
);
    // Scan from the top so the lowest set bit is the last one to write id.
    always_comb begin
        valid = 1'b0;
        id    = 3'd0;
        for (int i = NDEV - 1; i >= 0; i--) begin
            if (req[i]) begin
                valid = 1'b1;
                id    = 3'(i);
            end
        end
    end
endmodule

// File: rtl/io_intr_ctrl.sv
// rtl/io_intr_ctrl.sv - I/O-bus interrupt controller with single INTR/INTA/EOI handshake; IO_INTR_SYNC_EN adds a 2-flop IRQ synchronizer
module io_intr_ctrl
    import io_intr_pkg::*;
#(
    parameter int              BITS = 32,
    parameter logic [BITS-1:0] BASE = 32'hF0000800,
    parameter int              NDEV = 4
) (
    input  logic            CLK,
    input  logic            RESET,
    input  logic [BITS-1:0] ABUS,
    inout  wire  [BITS-1:0] DBUS,
    input  logic            WE,
    input  logic [NDEV-1:0] IRQ,
    input  logic            INTA,
    output logic            INTR,
    output logic [2:0]      IVEC
);
    localparam logic [BITS-1:0] PEND_ADDR = BASE + BITS'(PEND_OFS);
    localparam logic [BITS-1:0] MASK_ADDR = BASE + BITS'(MASK_OFS);
    localparam logic [BITS-1:0] CTRL_ADDR = BASE + BITS'(CTRL_OFS);
    localparam logic [BITS-1:0] EOI_ADDR  = BASE + BITS'(EOI_OFS);

    intr_state_t     state;
    logic [NDEV-1:0] irq_s, irq_d, pend, mask, rise, eligible;
    logic [NDEV-1:0] ivec_onehot, pend_clr, w1c_bits;
    logic            gie, win_valid, cur_live, inta_take;
    logic            wr_pend, wr_mask, wr_ctrl, wr_eoi;
    logic [2:0]      win_id;
    logic [BITS-1:0] rd_data;
    logic            rd_en;
    logic            unused_dbus;

`ifdef IO_INTR_SYNC_EN
    logic [NDEV-1:0] irq_meta, irq_sync;

    always_ff @(posedge CLK) begin
        if (RESET) begin
            irq_meta <= '0;
            irq_sync <= '0;
        end else begin
            irq_meta <= IRQ;
            irq_sync <= irq_meta;
        end
    end
    assign irq_s = irq_sync;
`else
    assign irq_s = IRQ;
`endif

    assign wr_pend = WE && (ABUS == PEND_ADDR);
    assign wr_mask = WE && (ABUS == MASK_ADDR);
    assign wr_ctrl = WE && (ABUS == CTRL_ADDR);
    assign wr_eoi  = WE && (ABUS == EOI_ADDR);

    assign rise        = irq_s & ~irq_d;
    assign ivec_onehot = NDEV'(1) << IVEC;
    assign inta_take   = (state == REQ) && INTA;
    assign w1c_bits    = wr_pend ? DBUS[NDEV-1:0] : '0;
    assign pend_clr    = w1c_bits | (inta_take ? ivec_onehot : '0);
    assign eligible    = gie ? (pend & mask) : '0;
    assign cur_live    = gie && (|(pend & mask & ivec_onehot));
    assign unused_dbus = ^DBUS;

    io_intr_prio #(.NDEV(NDEV)) u_prio (
        .req   (eligible),
        .valid (win_valid),
        .id    (win_id)
    );

    // A new edge is OR-ed in after clearing, so a same-cycle set beats W1C or INTA.
    always_ff @(posedge CLK) begin
        if (RESET) begin
            irq_d <= '0;
            pend  <= '0;
            mask  <= '0;
            gie   <= 1'b0;
        end else begin
            irq_d <= irq_s;
            pend  <= (pend & ~pend_clr) | rise;
            if (wr_mask) mask <= DBUS[NDEV-1:0];
            if (wr_ctrl) gie  <= DBUS[CTRL_GIE_BIT];
        end
    end

    always_ff @(posedge CLK) begin
        if (RESET) begin
            state <= IDLE;
            INTR  <= 1'b0;
            IVEC  <= 3'd0;
        end else begin
            case (state)
                IDLE: begin
                    if (win_valid) begin
                        IVEC  <= win_id;
                        state <= REQ;
                        INTR  <= 1'b1;
                    end
                end
                REQ: begin
                    if (INTA) begin
                        state <= SVC;
                        INTR  <= 1'b0;
                    end else if (!cur_live) begin
                        state <= IDLE;
                        INTR  <= 1'b0;
                    end
                end
                SVC: begin
                    if (wr_eoi) state <= IDLE;
                end
                default: begin
                    state <= IDLE;
                    INTR  <= 1'b0;
                end
            endcase
        end
    end

    always_comb begin
        rd_en   = !WE;
        rd_data = '0;
        case (ABUS)
            PEND_ADDR: rd_data[NDEV-1:0] = pend;
            MASK_ADDR: rd_data[NDEV-1:0] = mask;
            CTRL_ADDR: begin
                rd_data[CTRL_GIE_BIT]            = gie;
                rd_data[CTRL_INSVC_BIT]          = (state == SVC);
                rd_data[CTRL_IVEC_LSB +: 3]      = IVEC;
            end
            EOI_ADDR:  rd_data = '0;
            default:   rd_en = 1'b0;
        endcase
    end

    assign DBUS = rd_en ? rd_data : 'z;
endmodule

// File: tb/tb_io_intr_ctrl.sv
// tb/tb_io_intr_ctrl.sv - self-checking bench for io_intr_ctrl (vector table, corner sequences, random vs model)
module tb_io_intr_ctrl;
    localparam logic [31:0] BASE = 32'hF0000800;
`ifdef IO_INTR_SYNC_EN
    localparam int SYNC_EXTRA = 2;
`else
    localparam int SYNC_EXTRA = 0;
`endif
    localparam int EXP_LAT = 2 + SYNC_EXTRA;

    logic        CLK = 1'b0;
    logic        RESET;
    logic [31:0] ABUS;
    logic        WE;
    logic [3:0]  IRQ;
    logic        INTA;
    logic        INTR;
    logic [2:0]  IVEC;
    wire  [31:0] DBUS;
    logic [31:0] tb_drv;
    logic        tb_drv_en;

    assign DBUS = tb_drv_en ? tb_drv : 'z;

    int n_checks = 0;
    int n_fail   = 0;

    io_intr_ctrl #(.BITS(32), .BASE(BASE), .NDEV(4)) dut (
        .CLK   (CLK),
        .RESET (RESET),
        .ABUS  (ABUS),
        .DBUS  (DBUS),
        .WE    (WE),
        .IRQ   (IRQ),
        .INTA  (INTA),
        .INTR  (INTR),
        .IVEC  (IVEC)
    );

    always #5 CLK = ~CLK;

    typedef struct {
        logic        we;
        logic [3:0]  wofs;
        logic [31:0] wdata;
        logic [3:0]  irq;
        logic        inta;
        logic        exp_intr;
        logic [2:0]  exp_ivec;
        logic [3:0]  rofs;
        logic [31:0] exp_rd;
    } vec_t;

    vec_t        vecs[$];
    vec_t        v;
    logic [31:0] rd;
    int          cyc, n_intr;

    // reference model state
    logic [3:0]  m_pend, m_mask, m_irqd, m_s1, m_s2, m_eff, m_rise, m_clr, m_elig;
    logic        m_gie, m_req, m_svc;
    logic [2:0]  m_id;
    logic        c_we, c_inta;
    logic [3:0]  c_ofs, c_irq;
    logic [31:0] c_wd;
    int          op;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge CLK);
        #1;
    endtask

    task automatic ticks(input int n);
        for (int k = 0; k < n; k++) tick();
    endtask

    task automatic clear_bus();
        WE = 1'b0;
        tb_drv_en = 1'b0;
        tb_drv = 32'h0;
        ABUS = 32'h0;
    endtask

    task automatic set_write(input logic [3:0] ofs, input logic [31:0] d);
        WE = 1'b1;
        tb_drv_en = 1'b1;
        tb_drv = d;
        ABUS = BASE + {28'd0, ofs};
    endtask

    task automatic bus_write(input logic [3:0] ofs, input logic [31:0] d);
        set_write(ofs, d);
        tick();
        clear_bus();
    endtask

    task automatic bus_read(input logic [3:0] ofs, output logic [31:0] d);
        WE = 1'b0;
        tb_drv_en = 1'b0;
        ABUS = BASE + {28'd0, ofs};
        #1;
        d = DBUS;
    endtask

    task automatic wait_intr(input int lim, output int n);
        n = 0;
        while (!INTR && n < lim) begin
            tick();
            n++;
        end
    endtask

    task automatic add(input logic we, input logic [3:0] wofs, input logic [31:0] wdata,
                       input logic [3:0] irq, input logic inta, input logic exp_intr,
                       input logic [2:0] exp_ivec, input logic [3:0] rofs, input logic [31:0] exp_rd);
        vec_t t;
        t.we = we; t.wofs = wofs; t.wdata = wdata; t.irq = irq; t.inta = inta;
        t.exp_intr = exp_intr; t.exp_ivec = exp_ivec; t.rofs = rofs; t.exp_rd = exp_rd;
        vecs.push_back(t);
    endtask

    function automatic logic [2:0] lowest(input logic [3:0] b);
        for (int i = 0; i < 4; i++)
            if (b[i]) return 3'(i);
        return 3'd0;
    endfunction

    function automatic logic [31:0] model_reg(input logic [3:0] ofs);
        case (ofs)
            4'h0:    return {28'd0, m_pend};
            4'h4:    return {28'd0, m_mask};
            4'h8:    return {25'd0, m_id, 2'b00, m_svc, m_gie};
            default: return 32'd0;
        endcase
    endfunction

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        clear_bus();
        RESET = 1'b1; IRQ = 4'h0; INTA = 1'b0;
        ticks(3);
        RESET = 1'b0;
        check("reset intr", INTR, 0);
        check("reset ivec", IVEC, 0);
        bus_read(4'h0, rd); check("reset pend", rd, 0);
        bus_read(4'h4, rd); check("reset mask", rd, 0);
        bus_read(4'h8, rd); check("reset ctrl", rd, 0);
        ABUS = BASE + 32'h10; tb_drv = 32'h5A5A00F0; tb_drv_en = 1'b1; #1;
        check("unmapped bus released", DBUS, 32'h5A5A00F0);
        clear_bus();

        // we, wofs, wdata, irq, inta | intr, ivec, read ofs, read value
        add(1, 4'h4, 32'h6, 4'h0, 0, 0, 0, 4'h4, 32'h06);
        add(1, 4'h8, 32'h1, 4'h0, 0, 0, 0, 4'h8, 32'h01);
        add(0, 4'h0, 32'h0, 4'h4, 0, 0, 0, 4'h0, 32'h04);
        add(0, 4'h0, 32'h0, 4'h4, 0, 1, 2, 4'h8, 32'h21);
        add(0, 4'h0, 32'h0, 4'h4, 1, 0, 2, 4'h0, 32'h00);
        add(0, 4'h0, 32'h0, 4'h4, 0, 0, 2, 4'h8, 32'h23);
        add(1, 4'hC, 32'h0, 4'h4, 0, 0, 2, 4'h8, 32'h21);
        add(0, 4'h0, 32'h0, 4'h0, 0, 0, 2, 4'h0, 32'h00);
        add(1, 4'h4, 32'hF, 4'h0, 0, 0, 2, 4'h4, 32'h0F);
        add(0, 4'h0, 32'h0, 4'hA, 0, 0, 2, 4'h0, 32'h0A);
        add(0, 4'h0, 32'h0, 4'hA, 0, 1, 1, 4'h0, 32'h0A);
        add(0, 4'h0, 32'h0, 4'hA, 1, 0, 1, 4'h0, 32'h08);
        add(0, 4'h0, 32'h0, 4'hA, 0, 0, 1, 4'h8, 32'h13);
        add(1, 4'hC, 32'h0, 4'hA, 0, 0, 1, 4'h8, 32'h11);
        add(0, 4'h0, 32'h0, 4'hA, 0, 1, 3, 4'h8, 32'h31);
        add(0, 4'h0, 32'h0, 4'hA, 1, 0, 3, 4'h0, 32'h00);
        add(1, 4'hC, 32'h0, 4'h0, 0, 0, 3, 4'h8, 32'h31);
        add(0, 4'h0, 32'h0, 4'h0, 1, 0, 3, 4'hC, 32'h00);
        add(1, 4'hC, 32'h5, 4'h0, 0, 0, 3, 4'h8, 32'h31);
        add(1, 4'h4, 32'h4, 4'h0, 0, 0, 3, 4'h4, 32'h04);
        add(0, 4'h0, 32'h0, 4'h4, 0, 0, 3, 4'h0, 32'h04);
        add(0, 4'h0, 32'h0, 4'h4, 0, 1, 2, 4'h0, 32'h04);
        add(1, 4'h4, 32'h0, 4'h4, 0, 1, 2, 4'h4, 32'h00);
        add(0, 4'h0, 32'h0, 4'h4, 0, 0, 2, 4'h0, 32'h04);
        add(1, 4'h4, 32'h4, 4'h4, 0, 0, 2, 4'h4, 32'h04);
        add(0, 4'h0, 32'h0, 4'h4, 0, 1, 2, 4'h0, 32'h04);
        add(1, 4'h0, 32'h4, 4'h4, 1, 0, 2, 4'h8, 32'h23);
        add(1, 4'hC, 32'h0, 4'h0, 0, 0, 2, 4'h0, 32'h00);

        foreach (vecs[i]) begin
            v = vecs[i];
            if (v.irq != IRQ) begin
                IRQ = v.irq;
                ticks(SYNC_EXTRA);
            end
            INTA = v.inta;
            if (v.we) set_write(v.wofs, v.wdata);
            else clear_bus();
            tick();
            clear_bus();
            INTA = 1'b0;
            check($sformatf("vec%0d intr", i), INTR, v.exp_intr);
            check($sformatf("vec%0d ivec", i), IVEC, v.exp_ivec);
            bus_read(v.rofs, rd);
            check($sformatf("vec%0d read", i), rd, v.exp_rd);
        end

        // IRQ edge and W1C on the same bit in the same cycle: the set wins
        IRQ = 4'h1;
        ticks(SYNC_EXTRA);
        bus_write(4'h0, 32'h1);
        bus_read(4'h0, rd); check("set beats w1c", rd, 32'h1);
        bus_write(4'h0, 32'h1);
        bus_read(4'h0, rd); check("w1c with irq held", rd, 32'h0);

        // IRQ[0] held high for 20 cycles yields exactly one handshake
        bus_write(4'h4, 32'h1);
        IRQ = 4'h0;
        ticks(1 + SYNC_EXTRA);
        IRQ = 4'h1;
        n_intr = 0;
        for (int k = 0; k < 20; k++) begin
            tick();
            if (INTR) begin
                n_intr++;
                INTA = 1'b1;
                tick();
                INTA = 1'b0;
                bus_write(4'hC, 32'h0);
            end
        end
        check("held irq handshakes", n_intr, 1);
        bus_read(4'h0, rd); check("held irq pend", rd, 0);

        // a higher-priority arrival does not retarget a pending request
        IRQ = 4'h0;
        ticks(1 + SYNC_EXTRA);
        bus_write(4'h4, 32'hF);
        IRQ = 4'h4;
        wait_intr(10, cyc);
        check("rearb first intr", INTR, 1);
        check("rearb first ivec", IVEC, 2);
        IRQ = 4'h5;
        ticks(3 + SYNC_EXTRA);
        check("rearb held intr", INTR, 1);
        check("rearb held ivec", IVEC, 2);
        INTA = 1'b1; tick(); INTA = 1'b0;
        bus_write(4'hC, 32'h0);
        wait_intr(10, cyc);
        check("rearb second intr", INTR, 1);
        check("rearb second ivec", IVEC, 0);
        INTA = 1'b1; tick(); INTA = 1'b0;
        bus_write(4'hC, 32'h0);

        // IRQ-to-INTR latency, then reset in the middle of service
        IRQ = 4'h0;
        ticks(2 + SYNC_EXTRA);
        IRQ = 4'h2;
        wait_intr(10, cyc);
        check("latency cycles", cyc, EXP_LAT);
        check("latency ivec", IVEC, 1);
        INTA = 1'b1; tick(); INTA = 1'b0;
        bus_read(4'h8, rd); check("svc ctrl", rd, 32'h13);
        RESET = 1'b1; IRQ = 4'h0;
        tick();
        RESET = 1'b0;
        check("svc reset intr", INTR, 0);
        check("svc reset ivec", IVEC, 0);
        bus_read(4'h8, rd); check("svc reset ctrl", rd, 0);
        bus_read(4'h4, rd); check("svc reset mask", rd, 0);
        bus_read(4'h0, rd); check("svc reset pend", rd, 0);

        // randomized traffic against the reference model
        RESET = 1'b1; clear_bus();
        tick();
        RESET = 1'b0;
        m_pend = 0; m_mask = 0; m_irqd = 0; m_s1 = 0; m_s2 = 0;
        m_gie = 0; m_req = 0; m_svc = 0; m_id = 0;
        for (int n = 0; n < 400; n++) begin
            op = $urandom_range(0, 9);
            IRQ = IRQ ^ (($urandom_range(0, 3) == 0) ? 4'($urandom) : 4'h0);
            INTA = m_req ? ($urandom_range(0, 2) == 0) : ($urandom_range(0, 9) == 0);
            case (op)
                0, 1, 2, 3: begin
                    bus_read(4'(op * 4), rd);
                    check($sformatf("rand%0d read%0d", n, op * 4), rd, model_reg(4'(op * 4)));
                end
                4: set_write(4'h4, {28'd0, 4'($urandom)});
                5: set_write(4'h8, ($urandom & 32'hFFFFFFF0) | {31'd0, $urandom_range(0, 3) != 0});
                6: set_write(4'h0, $urandom);
                7: set_write(4'hC, $urandom);
                default: clear_bus();
            endcase
            c_we = WE; c_ofs = ABUS[3:0]; c_wd = tb_drv; c_inta = INTA; c_irq = IRQ;
            tick();
            clear_bus();

`ifdef IO_INTR_SYNC_EN
            m_eff = m_s2;
`else
            m_eff = c_irq;
`endif
            m_rise = m_eff & ~m_irqd;
            m_clr = (c_we && c_ofs == 4'h0) ? c_wd[3:0] : 4'h0;
            if (m_req && c_inta) m_clr[m_id] = 1'b1;
            if (m_req) begin
                if (c_inta) begin
                    m_req = 1'b0;
                    m_svc = 1'b1;
                end else if (!m_pend[m_id] || !m_mask[m_id] || !m_gie) begin
                    m_req = 1'b0;
                end
            end else if (m_svc) begin
                if (c_we && c_ofs == 4'hC) m_svc = 1'b0;
            end else begin
                m_elig = m_gie ? (m_pend & m_mask) : 4'h0;
                if (m_elig != 0) begin
                    m_id = lowest(m_elig);
                    m_req = 1'b1;
                end
            end
            m_pend = (m_pend & ~m_clr) | m_rise;
            if (c_we && c_ofs == 4'h4) m_mask = c_wd[3:0];
            if (c_we && c_ofs == 4'h8) m_gie = c_wd[0];
            m_irqd = m_eff; m_s2 = m_s1; m_s1 = c_irq;

            check($sformatf("rand%0d intr", n), INTR, m_req);
            check($sformatf("rand%0d ivec", n), IVEC, m_id);
        end
        INTA = 1'b0;

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule

// File: doc/io_intr_ctrl.md
Name: io_intr_ctrl

Overview:
- Memory-mapped interrupt controller on the processor's ABUS/DBUS I/O bus.
- Collects per-device ready strobes (switch, key and timer devices) into pending bits and applies a mask and a global enable.
- Picks one source by fixed priority and sequences a single INTR/INTA/EOI handshake with the processor.
- Only one interrupt is in service at a time; no nesting.

Parameters:
- BITS, 32, bus address/data width.
- BASE, 32'hF0000800, base address of the register block.
- NDEV, 4, number of interrupt sources (1..8).

Ports:
- CLK  input  1  system clock; all state updates on posedge.
- RESET  input  1  synchronous, active-high reset, sampled on posedge CLK.
- ABUS  input  BITS  address bus.
- DBUS  inout  BITS  data bus; driven only on a register read, else high-Z.
- WE  input  1  bus write enable; a read is !WE with an address match.
- IRQ  input  NDEV  device request lines; a rising edge raises a request.
- INTA  input  1  processor acknowledge, one cycle high.
- INTR  output  1  interrupt request to the processor.
- IVEC  output  3  ID of the source being requested or serviced.

Behaviour:
- Register map (word offsets):
  - PEND at BASE+0: read gives pending bits. A write clears every bit whose DBUS bit is 1 (W1C).
  - MASK at BASE+4: read/write; bit i = 1 enables source i.
  - CTRL at BASE+8: bit0 GIE (rw), bit1 INSVC (ro), bits[6:4] IVEC (ro), other bits read 0.
  - EOI at BASE+'hC: a write of any value ends service; reads return 0.
- Reads are combinational: DBUS = zero-extended register when !WE and address matches, else all Z.
- Edge detect: register IRQ_d each cycle. PEND[i] is set when IRQ[i] & !IRQ_d[i].
- PEND set/clear conflict: if a set and a clear hit the same bit in the same cycle (W1C or INTA), set wins.
- Eligible set = PEND & MASK; it counts only when GIE = 1.
- Winner = lowest-index eligible bit.
- FSM states: IDLE, REQ, SVC.
  - IDLE: if any eligible bit, latch the winner into IVEC and go to REQ next cycle. INTR=0.
  - REQ: INTR=1. On INTA=1: clear PEND[IVEC], go to SVC.
  - REQ withdraw: if PEND[IVEC] or MASK[IVEC] clears, or GIE=0, with no INTA in that cycle, go back to IDLE. INTR drops the next cycle.
  - REQ re-arbitration: a higher-priority source becoming pending does NOT change IVEC while in REQ.
  - SVC: INTR=0, INSVC=1. On a write to EOI go to IDLE. New requests stay pending.
- Simultaneous events:
  - INTA and withdraw in the same cycle: INTA wins.
  - EOI write outside SVC: ignored.
  - INTA outside REQ: ignored.
- Latency: an IRQ rising edge with mask and GIE set gives INTR=1 two cycles after the edge is sampled (PEND set, then REQ).
- RESET:
  - PEND=0, MASK=0, GIE=0, IRQ_d=0, IVEC=0, INTR=0, state=IDLE.
  - Applies at any point, including mid-REQ/SVC; an in-flight handshake is abandoned.
- An IRQ held high produces exactly one pending event.

Optional Feature:
- Macro IO_INTR_SYNC_EN.
- Defined: IRQ passes through a two-flop synchronizer (reset to 0) before edge detection, adding 2 cycles to the IRQ-to-INTR latency. For IRQs from the CLK_50-derived domains.
- Undefined: IRQ is used directly and must be synchronous to CLK.

Decomposition:
- Shared package io_intr_pkg holds:
  - Register offsets (PEND_OFS=0, MASK_OFS=4, CTRL_OFS=8, EOI_OFS='hC).
  - CTRL bit positions.
  - FSM state encoding (IDLE=2'd0, REQ=2'd1, SVC=2'd2).
- One sub-module, io_intr_prio: combinational NDEV-bit lowest-index priority encoder with outputs valid and id[2:0].

Test Plan:
- Reset, then read PEND/MASK/CTRL -> all 0, DBUS Z when not selected, INTR=0.
- MASK=4'b0110, GIE=1, IRQ[2] rises -> INTR=1 two cycles later, IVEC=2; INTA -> INTR=0, INSVC=1, PEND=0; EOI write -> INSVC=0, state IDLE.
- IRQ[1] and IRQ[3] rise together with MASK=4'hF -> IVEC=1 served first; after EOI, IVEC=3 requested.
- In REQ with IVEC=2, write MASK=4'b0000 -> INTR drops next cycle, PEND[2] stays 1; restoring MASK=4'b0100 -> re-request with IVEC=2.
- W1C write PEND=4'b0001 in the same cycle as an IRQ[0] rising edge -> PEND[0] reads 1. IRQ[0] held high for 20 cycles -> only one INTR/INTA sequence.
- Assert RESET during SVC -> next cycle INTR=0, INSVC=0, MASK=0; with IO_INTR_SYNC_EN defined, IRQ-to-INTR latency measures 4 cycles.
